// File: rtl/multi_hot_encoder_pkg.sv
// Shared types and helpers for the multi-hot encoder.
package multi_hot_encoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Index width for an N-bit vector; kept at least 1 so ports never collapse.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_hot_encoder_lsb_index_encoder.sv
// Lowest-set-bit priority encoder: reports the index of the lowest set bit
// (0 when the vector is empty) and whether at most one bit is set.
module lsb_index_encoder
    import multi_hot_encoder_pkg::*;
#(
    parameter int N = 8
)
(
    input  logic [N-1:0]              vec,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      single
);

    localparam int W = idx_width(N);

    logic [N-1:0] w_vec_dec;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
    always_comb begin
        w_vec_dec = vec - {{(N-1){1'b0}}, 1'b1};
        single    = ((vec & w_vec_dec) == '0);
    end

endmodule

// File: rtl/multi_hot_encoder.sv
// Multi-hot encoder: accepts an N-bit vector and emits the index of every
// set bit, lowest first, one beat per index. All outputs come from registers.
module multi_hot_encoder
    import multi_hot_encoder_pkg::*;
#(
    parameter int N = 8
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              in_vec,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [idx_width(N)-1:0]   out_idx,
    output logic                      out_none,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int W = idx_width(N);

    state_t         r_state;
    logic [N-1:0]   r_pend;
    logic           r_zero_flag;

    state_t         w_state_nxt;
    logic [N-1:0]   w_pend_nxt;
    logic           w_zero_nxt;
    logic [W-1:0]   w_idx;
    logic           w_single;
    logic [N-1:0]   w_pend_dec;

    lsb_index_encoder #(.N(N)) u_lsb_enc (
        .vec    (r_pend),
        .idx    (w_idx),
        .single (w_single)
    );

    // State and pending-bit registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_zero_flag <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_zero_flag <= w_zero_nxt;
        end
    end

    // Next-state: capture in IDLE, retire the lowest pending bit per beat in EMIT.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_zero_nxt  = r_zero_flag;
        w_pend_dec  = r_pend - {{(N-1){1'b0}}, 1'b1};
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_pend_nxt  = in_vec;
                    w_zero_nxt  = (in_vec == '0);
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (w_single) begin
                        w_state_nxt = IDLE;
                        w_pend_nxt  = '0;
                        w_zero_nxt  = 1'b0;
                    end else begin
                        w_pend_nxt  = r_pend & w_pend_dec;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pend_nxt  = '0;
                w_zero_nxt  = 1'b0;
            end
        endcase
    end

    // Outputs decoded from registered state only; nothing flows through from inputs.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == EMIT);
        out_idx   = (r_state == EMIT) ? w_idx : '0;
        out_none  = (r_state == EMIT) ? r_zero_flag : 1'b0;
        out_last  = (r_state == EMIT) ? w_single : 1'b0;
    end

endmodule

// File: tb/tb_multi_hot_encoder.sv
// Scoreboard bench for multi_hot_encoder with N=8.
module tb_multi_hot_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] in_vec;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_idx;
    logic       out_none;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    typedef struct packed {
        logic [2:0] idx;
        logic       none;
        logic       last;
    } beat_t;

    beat_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    multi_hot_encoder #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] idx, input logic none, input logic last);
        beat_t b;
        b.idx  = idx;
        b.none = none;
        b.last = last;
        sb_q.push_back(b);
    endtask

    // Monitor: compare every real output handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat actual idx=%0d none=%0b last=%0b expected no beat",
                         out_idx, out_none, out_last);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                if (out_idx !== e.idx || out_none !== e.none || out_last !== e.last) begin
                    failures++;
                    $display("FAIL beat actual idx=%0d none=%0b last=%0b expected idx=%0d none=%0b last=%0b",
                             out_idx, out_none, out_last, e.idx, e.none, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) check("wait_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Present a vector for exactly one accepting edge.
    task automatic send(input logic [7:0] v);
        wait_ready();
        in_vec   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_vec   = '0;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_vec    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset
        tick();
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_none",  32'(out_none),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        rst = 1'b0;
        tick();

        // Multi-hot stream 1001_0100 -> 2,4,7
        out_ready = 1'b1;
        push(3'd2, 1'b0, 1'b0);
        push(3'd4, 1'b0, 1'b0);
        push(3'd7, 1'b0, 1'b1);
        send(8'b1001_0100);
        check("mh_first_valid",   32'(out_valid), 32'd1);
        check("mh_in_ready_busy", 32'(in_ready),  32'd0);
        tick();
        tick();
        tick();
        check("mh_in_ready_after", 32'(in_ready), 32'd1);

        // Zero vector -> single beat idx 0, none, last
        push(3'd0, 1'b1, 1'b1);
        send(8'h00);
        check("zero_valid", 32'(out_valid), 32'd1);
        tick();
        check("zero_in_ready_after", 32'(in_ready), 32'd1);

        // Backpressure with an ignored input pulse during EMIT
        out_ready = 1'b0;
        push(3'd0, 1'b0, 1'b0);
        push(3'd7, 1'b0, 1'b1);
        send(8'b1000_0001);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_idx",   32'(out_idx),   32'd0);
            check("bp_last",  32'(out_last),  32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            in_vec   = 8'hFF;
            in_valid = (i == 1);
            tick();
        end
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_no_extra_valid", 32'(out_valid), 32'd0);

        // Full vector: 8 beats, 9 cycles accept-to-ready including the accept cycle
        for (int i = 0; i < 8; i++) push(3'(i), 1'b0, (i == 7));
        send(8'hFF);
        n = 1;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("full_cycles", 32'(n), 32'd9);

        // Reset mid-operation: only idx 3 may appear
        push(3'd3, 1'b0, 1'b0);
        send(8'b0011_1000);
        check("mid_idx3_present", 32'(out_idx), 32'd3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid",    32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready),  32'd1);
        for (int i = 0; i < 6; i++) tick();
        check("mid_rst_idle_valid", 32'(out_valid), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_hot_encoder.md
Name: multi_hot_encoder

Overview:
- Sequential encoder: the inverse of the team's 2-to-4 decoder-based gate blocks. It maps a one-hot or multi-hot bit vector back to binary indices.
- Accepts an N-bit request vector over a valid/ready handshake.
- Emits the binary index of every set bit, lowest first, one beat per index over a second valid/ready handshake.
- Used wherever decoded select lines must be re-encoded, e.g. for checking decoder outputs or serialising request sets.

Parameters:
- N, 8, width of the input vector (N >= 2).
- W, $clog2(N), width of the output index; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_vec  input  N  request vector.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- out_idx  output  W  binary index of the current lowest pending set bit.
- out_none  output  1  accepted vector was all zeros.
- out_last  output  1  current beat is the final beat for this vector.
- out_valid  output  1  out_idx, out_none and out_last are valid.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- State machine with two states, IDLE and EMIT. Registers: state, pend[N-1:0], zero_flag.
- Reset (rst=1 at the clock edge):
  - state=IDLE, pend=0, zero_flag=0.
  - Outputs: in_ready=1, out_valid=0, out_idx=0, out_none=0, out_last=0.
  - Applies from any state. A vector in progress is discarded and no further beats are emitted.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: pend<=in_vec, zero_flag<=(in_vec==0), state<=EMIT.
- EMIT:
  - in_ready=0; in_valid is ignored and no vector is captured.
  - out_valid=1.
  - out_idx = index of the lowest set bit of pend; 0 when pend==0.
  - out_none = zero_flag.
  - out_last = 1 when pend has at most one bit set.
  - On out_valid&&out_ready:
    - If out_last: state<=IDLE, pend<=0, zero_flag<=0.
    - Else: clear the lowest set bit of pend (pend <= pend & (pend-1)).
- Latency and throughput:
  - First out_valid is asserted the cycle after input acceptance.
  - Beats for one vector are back-to-back while out_ready=1.
  - in_ready returns high the cycle after the last beat handshake.
  - Cost per vector is max(popcount,1)+1 cycles.
- Outputs are decoded only from registers. There is no combinational path from in_vec/in_valid to any output, or from out_ready to out_*.
- Backpressure: while out_valid=1 and out_ready=0, out_idx/out_none/out_last are held stable.
- All-zero vector: exactly one beat with out_idx=0, out_none=1, out_last=1.
- All-ones vector: N beats with indices 0..N-1; out_last only on index N-1.
- Bit N-1 set alone: a single beat with out_idx=N-1 and out_last=1. No wrap or overflow is possible because W=$clog2(N).
- rst has priority over any simultaneous handshake in the same cycle.

Decomposition:
- Shared package multi_hot_encoder_pkg holds:
  - state typedef enum {IDLE, EMIT}.
  - a function or constant for computing W from N.
- One combinational sub-module, lsb_index_encoder (parameter N):
  - input vec[N-1:0]; outputs idx[W-1:0], single (at most one bit set).
  - Lowest-set-bit priority encoder.
  - Instantiated once on pend; unit-testable in isolation.
- The top level holds the FSM, pend register and handshake logic.

Test Plan (N=8):
1. Reset: hold rst=1 for 2 cycles -> in_ready=1, out_valid=0, out_idx=0, out_none=0, out_last=0.
2. Multi-hot stream: in_vec=8'b1001_0100 accepted, out_ready=1 throughout:
   - next cycles give out_idx=2,4,7, with out_last=1 only on 7 and out_none=0;
   - in_ready=1 the cycle after the idx=7 handshake.
3. Zero vector: in_vec=8'h00 accepted -> single beat out_idx=0, out_none=1, out_last=1; then IDLE.
4. Backpressure:
   - in_vec=8'b1000_0001 accepted, out_ready=0 for 3 cycles -> out_idx=0, out_last=0 held stable;
   - raise out_ready -> beats idx 0 then idx 7 (last=1).
   - in_valid pulsed with 8'hFF during EMIT must be ignored: no extra beats.
5. Full vector: in_vec=8'hFF, out_ready=1 -> 8 consecutive beats with idx 0..7; out_last only on beat 7; total 9 cycles from accept to in_ready high.
6. Reset mid-operation:
   - in_vec=8'b0011_1000 accepted; after the idx=3 handshake assert rst=1 for one cycle;
   - the next cycle shows out_valid=0 and in_ready=1, and no beats for idx 4 or 5 ever appear.
